cmd_sequencer: RTL and testbench

Command sequencer that sits directly upstream of the command/display FSM. It debounces the KEY0 pushbutton into a clean level for that FSM's push-button input and drives the 3-bit `cmd` bus it consumes. It also accepts keyword-classification results from the ARM (HPS) over a valid/ready handshake, gates them on confidence, and holds the recognised command for a bounded time before returning to WELCOME.

---
 rtl/voice_pkg.sv | 34 +++
 rtl/key_debounce.sv | 59 +++++
 rtl/cmd_sequencer.sv | 174 +++++++++++++++++
 tb/tb_cmd_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_pkg.sv
// Shared types and default timing for the voice command path (sequencer and command FSM).
package voice_pkg;

  // Command codes carried on the 3-bit cmd bus.
  typedef enum logic [2:0] {
    WELCOME   = 3'd0,
    RECORDING = 3'd1,
    UP        = 3'd2,
    DOWN      = 3'd3,
    LEFT      = 3'd4,
    RIGHT     = 3'd5,
    STOP      = 3'd6,
    SILENCE   = 3'd7
  } cmd_t;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REC  = 2'd1,
    S_HOLD = 2'd2
  } seq_state_t;

  // Defaults for a 50 MHz clock.
  localparam int unsigned DEBOUNCE_CYC_DEF = 500000;     // 10 ms
  localparam int unsigned HOLD_CYC_DEF     = 100000000;  // 2 s
  localparam int unsigned REC_TO_CYC_DEF   = 150000000;  // 3 s
  localparam logic [7:0]  CONF_MIN_DEF     = 8'd128;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus debounce counter for an active-low pushbutton.
// Output 'stable' is the accepted key level (1 = released).
module key_debounce
  import voice_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic rstb,
  input  logic key_n_raw,
  output logic stable
);

  localparam int unsigned     CntW    = cnt_width(DEBOUNCE_CYC);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Synchroniser; resets to the released level.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_raw;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive samples that disagree with the accepted level; any agreeing
  // sample (a bounce back) restarts the count. The count tops out at CntLast.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q >= CntLast) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/cmd_sequencer.sv
// Command sequencer: debounced KEY0 drives IDLE -> REC, ARM results are gated on
// confidence and held on cmd. Optional macro CMD_HOLD_TIMEOUT_EN builds the hold
// timer that returns to WELCOME after HOLD_CYC cycles; without it S_HOLD persists.
module cmd_sequencer
  import voice_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int unsigned HOLD_CYC     = HOLD_CYC_DEF,
  parameter int unsigned REC_TO_CYC   = REC_TO_CYC_DEF,
  parameter logic [7:0]  CONF_MIN     = CONF_MIN_DEF
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       key_n_raw,
  output logic       btn_level,
  input  logic       arm_valid,
  output logic       arm_ready,
  input  logic [2:0] arm_cmd,
  input  logic [7:0] arm_conf,
  output logic [2:0] cmd,
  output logic       cmd_reject
);

  localparam int unsigned    WdW    = cnt_width(REC_TO_CYC);
  localparam logic [WdW-1:0] WdLast = WdW'(REC_TO_CYC - 1);

  logic       key_stable;
  logic       btn_prev_q;
  logic       press;
  seq_state_t state_q, state_d;
  cmd_t       cmd_q, cmd_d;
  logic       ready_q, ready_d;
  logic       reject_q, reject_d;
  logic [WdW-1:0] wd_q, wd_d;
  logic       handshake;
  logic       result_ok;
  logic       wd_expired;
  logic       hold_expired;

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_key_debounce (
    .clk      (clk),
    .rstb     (rstb),
    .key_n_raw(key_n_raw),
    .stable   (key_stable)
  );

  assign btn_level = ~key_stable;

  // Previous debounced level, for the press edge detector.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      btn_prev_q <= 1'b0;
    end else begin
      btn_prev_q <= btn_level;
    end
  end

  assign press      = btn_level & ~btn_prev_q;
  assign handshake  = arm_valid & ready_q;
  // Codes 0 and 1 are sequencer-internal and never valid classifier results.
  assign result_ok  = (arm_cmd >= 3'd2) && (arm_conf >= CONF_MIN);
  assign wd_expired = (wd_q >= WdLast);

`ifdef CMD_HOLD_TIMEOUT_EN
  localparam int unsigned      HoldW    = cnt_width(HOLD_CYC);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYC - 1);

  logic [HoldW-1:0] hold_q, hold_d;

  assign hold_expired = (hold_q >= HoldLast);

  // Hold timer runs only while S_HOLD persists; saturating.
  always_comb begin
    hold_d = '0;
    if (state_q == S_HOLD && state_d == S_HOLD) begin
      hold_d = (hold_q == '1) ? hold_q : hold_q + 1'b1;
    end
  end

  // Hold timer register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  // No hold timer: S_HOLD is left only by a press or reset, so HOLD_CYC has no effect.
  assign hold_expired = 1'b0;
  if (HOLD_CYC == 0) begin : g_hold_cyc_unused
  end
`endif

  // Next state and registered outputs; handshake beats watchdog, press beats hold expiry.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    ready_d  = ready_q;
    reject_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (press) begin
          state_d = S_REC;
          cmd_d   = RECORDING;
          ready_d = 1'b1;
        end
      end
      S_REC: begin
        if (handshake) begin
          state_d = S_HOLD;
          ready_d = 1'b0;
          if (result_ok) begin
            cmd_d = cmd_t'(arm_cmd);
          end else begin
            cmd_d    = SILENCE;
            reject_d = 1'b1;
          end
        end else if (wd_expired) begin
          state_d = S_IDLE;
          cmd_d   = WELCOME;
          ready_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (press) begin
          state_d = S_REC;
          cmd_d   = RECORDING;
          ready_d = 1'b1;
        end else if (hold_expired) begin
          state_d = S_IDLE;
          cmd_d   = WELCOME;
        end
      end
      default: begin
        state_d = S_IDLE;
        cmd_d   = WELCOME;
        ready_d = 1'b0;
      end
    endcase
  end

  // Recording watchdog runs only while S_REC persists; saturating.
  always_comb begin
    wd_d = '0;
    if (state_q == S_REC && state_d == S_REC) begin
      wd_d = (wd_q == '1) ? wd_q : wd_q + 1'b1;
    end
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= S_IDLE;
      cmd_q    <= WELCOME;
      ready_q  <= 1'b0;
      reject_q <= 1'b0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      ready_q  <= ready_d;
      reject_q <= reject_d;
      wd_q     <= wd_d;
    end
  end

  assign cmd        = cmd_q;
  assign arm_ready  = ready_q;
  assign cmd_reject = reject_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Bench for cmd_sequencer: directed stimulus, a deadline-based behavioural model
// compared every cycle, and hand-computed checkpoints. Follows CMD_HOLD_TIMEOUT_EN.
module tb_cmd_sequencer;

  localparam int unsigned DEB    = 4;
  localparam int unsigned HOLD   = 20;
  localparam int unsigned REC_TO = 50;
  localparam logic [7:0]  CMIN   = 8'd128;
  localparam int MIdle = 0, MRec = 1, MHold = 2;

  logic       clk = 1'b0;
  logic       rstb = 1'b1;
  logic       key_n_raw = 1'b1;
  logic       arm_valid = 1'b0;
  logic [2:0] arm_cmd = 3'd0;
  logic [7:0] arm_conf = 8'd0;
  logic       btn_level, arm_ready, cmd_reject;
  logic [2:0] cmd;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;
  int btn_rises = 0;
  logic btn_last = 1'b0;

  always #5 clk = ~clk;

  cmd_sequencer #(
    .DEBOUNCE_CYC(DEB),
    .HOLD_CYC    (HOLD),
    .REC_TO_CYC  (REC_TO),
    .CONF_MIN    (CMIN)
  ) dut (
    .clk       (clk),
    .rstb      (rstb),
    .key_n_raw (key_n_raw),
    .btn_level (btn_level),
    .arm_valid (arm_valid),
    .arm_ready (arm_ready),
    .arm_cmd   (arm_cmd),
    .arm_conf  (arm_conf),
    .cmd       (cmd),
    .cmd_reject(cmd_reject)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Key held low long enough to be accepted; returns when cmd should read RECORDING.
  task automatic do_press();
    key_n_raw = 1'b0;
    tick(7);
    key_n_raw = 1'b1;
  endtask

  // Behavioural model: key accepted after DEB consecutive disagreeing samples seen
  // through a two-sample delay; sequencer tracked with absolute-cycle deadlines.
  int   cyc, run, m_mode, deadline;
  logic h0, h1, samp, m_stable, m_btn, m_btn_prev, m_press, m_hs;
  logic [2:0] m_cmd;
  logic m_ready, m_reject;

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cyc = 0; run = 0; m_mode = MIdle; deadline = 0;
      h0 = 1'b1; h1 = 1'b1; m_stable = 1'b1; m_btn = 1'b0; m_btn_prev = 1'b0;
      m_cmd = 3'd0; m_ready = 1'b0; m_reject = 1'b0;
    end else begin
      cyc++;
      m_press  = m_btn && !m_btn_prev;
      m_hs     = arm_valid && m_ready;
      m_reject = 1'b0;
      case (m_mode)
        MIdle: if (m_press) begin
          m_mode = MRec; m_cmd = 3'd1; m_ready = 1'b1; deadline = cyc + REC_TO;
        end
        MRec: begin
          if (m_hs) begin
            m_mode = MHold; m_ready = 1'b0; deadline = cyc + HOLD;
            if (arm_cmd >= 3'd2 && arm_conf >= CMIN) m_cmd = arm_cmd;
            else begin m_cmd = 3'd7; m_reject = 1'b1; end
          end else if (cyc == deadline) begin
            m_mode = MIdle; m_cmd = 3'd0; m_ready = 1'b0;
          end
        end
        default: begin
          if (m_press) begin
            m_mode = MRec; m_cmd = 3'd1; m_ready = 1'b1; deadline = cyc + REC_TO;
          end
`ifdef CMD_HOLD_TIMEOUT_EN
          else if (cyc == deadline) begin
            m_mode = MIdle; m_cmd = 3'd0;
          end
`endif
        end
      endcase
      m_btn_prev = m_btn;
      samp = h1; h1 = h0; h0 = key_n_raw;
      if (samp != m_stable) begin
        run++;
        if (run == DEB) begin m_stable = samp; run = 0; end
      end else begin
        run = 0;
      end
      m_btn = !m_stable;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("model btn_level", btn_level, m_btn);
    chk("model cmd", cmd, m_cmd);
    chk("model arm_ready", arm_ready, m_ready);
    chk("model cmd_reject", cmd_reject, m_reject);
  end

  // Handshake and btn_level rise counters.
  always @(posedge clk) begin
    if (arm_valid && arm_ready) hs_cnt++;
    #1;
    if (btn_level && !btn_last) btn_rises++;
    btn_last = btn_level;
  end

  initial begin
    int rises0, hs0;
    #1 rstb = 1'b0;
    tick(3);
    chk("reset btn_level", btn_level, 0);
    chk("reset cmd", cmd, 0);
    chk("reset arm_ready", arm_ready, 0);
    chk("reset cmd_reject", cmd_reject, 0);
    rstb = 1'b1;
    tick(4);

    // Bounce: toggles every 2 cycles for 12 cycles, then held low.
    rises0 = btn_rises;
    for (int i = 0; i < 6; i++) begin
      key_n_raw = i[0];
      tick(2);
    end
    key_n_raw = 1'b0;
    tick(5);
    chk("bounce btn before +6", btn_level, 0);
    tick(1);
    chk("bounce btn at +6", btn_level, 1);
    chk("bounce cmd still WELCOME", cmd, 0);
    tick(1);
    chk("press cmd RECORDING", cmd, 1);
    chk("press arm_ready", arm_ready, 1);
    chk("bounce single rise", btn_rises - rises0, 1);

    // Accepted result.
    key_n_raw = 1'b1;
    arm_valid = 1'b1; arm_cmd = 3'd3; arm_conf = 8'd200;
    tick(1);
    chk("accept cmd", cmd, 3);
    chk("accept arm_ready low", arm_ready, 0);
    chk("accept no reject", cmd_reject, 0);
    arm_valid = 1'b0;
    tick(19);
    chk("hold before expiry", cmd, 3);
    tick(1);
`ifdef CMD_HOLD_TIMEOUT_EN
    chk("hold expiry WELCOME", cmd, 0);
`else
    chk("hold persists", cmd, 3);
`endif

    // Rejected results: low confidence, then an internal code.
    do_press();
    chk("re-press cmd", cmd, 1);
    arm_valid = 1'b1; arm_cmd = 3'd4; arm_conf = 8'd127;
    tick(1);
    chk("low conf SILENCE", cmd, 7);
    chk("low conf reject pulse", cmd_reject, 1);
    arm_valid = 1'b0;
    tick(1);
    chk("low conf reject one cycle", cmd_reject, 0);
    tick(8);
    do_press();
    arm_valid = 1'b1; arm_cmd = 3'd1; arm_conf = 8'd255;
    tick(1);
    chk("code1 SILENCE", cmd, 7);
    chk("code1 reject pulse", cmd_reject, 1);
    arm_valid = 1'b0;
    tick(1);
    chk("code1 reject one cycle", cmd_reject, 0);

    // Watchdog: 50 cycles of RECORDING, then a late result is never taken.
    tick(8);
    do_press();
    tick(49);
    chk("watchdog cmd at +49", cmd, 1);
    tick(1);
    chk("watchdog cmd at +50", cmd, 0);
    chk("watchdog arm_ready", arm_ready, 0);
    hs0 = hs_cnt;
    arm_valid = 1'b1; arm_cmd = 3'd2; arm_conf = 8'd200;
    tick(10);
    chk("late valid not acked", hs_cnt - hs0, 0);
    chk("late valid cmd", cmd, 0);
    arm_valid = 1'b0;

    // Handshake on the watchdog-expiry edge, confidence exactly at threshold.
    tick(2);
    do_press();
    tick(49);
    arm_valid = 1'b1; arm_cmd = 3'd2; arm_conf = 8'd128;
    tick(1);
    chk("handshake beats watchdog", cmd, 2);
    chk("conf==min no reject", cmd_reject, 0);
    arm_valid = 1'b0;

    // Press coinciding with a handshake in REC is dropped.
    do_press();
    tick(8);
    key_n_raw = 1'b0;
    tick(6);
    arm_valid = 1'b1; arm_cmd = 3'd6; arm_conf = 8'd255;
    tick(1);
    chk("press+handshake cmd", cmd, 6);
    arm_valid = 1'b0;
    tick(1);
    key_n_raw = 1'b1;
    chk("press dropped", cmd, 6);

    // Press on the hold-expiry edge.
    tick(12);
    key_n_raw = 1'b0;
    tick(7);
    chk("press beats hold expiry", cmd, 1);
    chk("press beats hold ready", arm_ready, 1);
    key_n_raw = 1'b1;

    // Asynchronous reset in REC with a pending result.
    tick(2);
    hs0 = hs_cnt;
    arm_valid = 1'b1; arm_cmd = 3'd3; arm_conf = 8'd200;
    #2 rstb = 1'b0;
    #1;
    chk("async reset btn_level", btn_level, 0);
    chk("async reset cmd", cmd, 0);
    chk("async reset arm_ready", arm_ready, 0);
    chk("async reset cmd_reject", cmd_reject, 0);
    tick(2);
    chk("reset pending not acked", hs_cnt - hs0, 0);
    arm_valid = 1'b0;
    rstb = 1'b1;
    tick(4);

    // Long hold of code 5.
    do_press();
    arm_valid = 1'b1; arm_cmd = 3'd5; arm_conf = 8'd255;
    tick(1);
    chk("accept RIGHT", cmd, 5);
    arm_valid = 1'b0;
`ifdef CMD_HOLD_TIMEOUT_EN
    tick(19);
    chk("RIGHT before expiry", cmd, 5);
    tick(1);
    chk("RIGHT expiry", cmd, 0);
`else
    tick(1000);
    chk("RIGHT held 1000 cycles", cmd, 5);
`endif
    do_press();
    chk("next press RECORDING", cmd, 1);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    n_fail++;
    $display("FAIL timeout: got running expected finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
